led_trail_pwm: RTL

Downstream stage of the rotating-LED pattern generator in the npc top level. Takes the 16-bit one-hot/rotating LED pattern plus an update strobe and drives the physical LED pins with per-LED PWM brightness. Lit LEDs go to full brightness, then fade linearly once their bit leaves the pattern. The result is a fading "comet tail" behind the rotating light.

---
 rtl/led_trail_pwm_if.sv | 25 ++
 rtl/led_trail_pwm.sv | 119 +++++++++++
 2 files changed

// File: rtl/led_trail_pwm_if.sv
// Pattern-in / LED-drive bundle between the LED rotator and led_trail_pwm.
// Ports: pat_in/pat_valid (rotator -> PWM stage); led_out/fade_active (PWM stage -> pins/status).
// master = pattern source (and observer of the drive), slave = led_trail_pwm itself.
interface led_trail_pwm_if #(
   parameter int N_LED = 16
);
   logic [N_LED-1:0] pat_in;
   logic             pat_valid;
   logic [N_LED-1:0] led_out;
   logic             fade_active;

   modport master (
      output pat_in,
      output pat_valid,
      input  led_out,
      input  fade_active
   );

   modport slave (
      input  pat_in,
      input  pat_valid,
      output led_out,
      output fade_active
   );
endinterface

// File: rtl/led_trail_pwm.sv
// Purpose: per-LED PWM with linear fade-out, giving a comet tail behind the rotating LED pattern.
// Latency: pat_valid updates the level on its own edge; led_out follows one edge later.
// Backpressure: none; a strobe is accepted on every clk edge it is high.
//
// Ports: clk, rst (synchronous, active-low), bus (led_trail_pwm_if.slave):
//   bus.pat_in/bus.pat_valid  pattern and strobe from the rotator
//   bus.led_out               registered PWM drive, one bit per LED
//   bus.fade_active           registered, high while any channel level is nonzero
// Build option: define LED_TRAIL_GAMMA_EN for a squared (perceptual) duty curve;
// without it the duty is the level itself and no multiplier is built.
module led_trail_pwm #(
   parameter int N_LED    = 16,
   parameter int PWM_BITS = 8,
   parameter int FADE_DIV = 50000,
   parameter int DECAY    = 16
) (
   input logic            clk,
   input logic            rst,
   led_trail_pwm_if.slave bus
);

   localparam int                  PRESC_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
   localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(FADE_DIV - 1);
   localparam logic [PWM_BITS-1:0] LMAX       = '1;
   // Decay step is taken modulo the level width.
   localparam logic [PWM_BITS-1:0] DECAY_W    = PWM_BITS'(DECAY);

   logic [PRESC_W-1:0]  presc_q, presc_d;
   logic                fade_tick;
   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [PWM_BITS-1:0] lvl_q [N_LED];
   logic [PWM_BITS-1:0] lvl_d [N_LED];
   logic [PWM_BITS-1:0] duty  [N_LED];
   logic [N_LED-1:0]    led_out_q, led_out_d;
   logic                fade_active_q, fade_active_d;

   // Fade prescaler: one fade_tick per FADE_DIV cycles, first one FADE_DIV
   // cycles after reset release.
   always_comb begin
      fade_tick = (presc_q == PRESC_LAST);
      presc_d   = fade_tick ? '0 : presc_q + 1'b1;
   end

   // PWM period is LMAX cycles (0..LMAX-1), so duty LMAX means solidly on
   // and duty 0 means solidly off.
   always_comb begin
      pwm_cnt_d = (pwm_cnt_q == LMAX - 1'b1) ? '0 : pwm_cnt_q + 1'b1;
   end

   // Level update: a set in the pattern wins over a coincident fade step;
   // a strobe with the bit clear leaves the channel fading.
   always_comb begin
      for (int i = 0; i < N_LED; i++) begin
         lvl_d[i] = lvl_q[i];
         if (bus.pat_valid && bus.pat_in[i]) begin
            lvl_d[i] = LMAX;
         end else if (fade_tick) begin
            lvl_d[i] = (lvl_q[i] > DECAY_W) ? lvl_q[i] - DECAY_W : '0;
         end
      end
   end

   // Level to duty mapping.
`ifdef LED_TRAIL_GAMMA_EN
   logic [2*PWM_BITS-1:0] sq;
   always_comb begin
      sq = '0;
      for (int i = 0; i < N_LED; i++) begin
         sq = {{PWM_BITS{1'b0}}, lvl_q[i]} * {{PWM_BITS{1'b0}}, lvl_q[i]};
         // The square of LMAX falls just short of LMAX after the shift;
         // pin full brightness so freshly lit LEDs do not flicker.
         duty[i] = (lvl_q[i] == LMAX) ? LMAX : PWM_BITS'(sq >> PWM_BITS);
      end
   end
`else
   always_comb begin
      for (int i = 0; i < N_LED; i++) begin
         duty[i] = lvl_q[i];
      end
   end
`endif

   // Registered outputs, driven from the current registered state; this is
   // the one cycle of lag between a level change and the pins/status.
   always_comb begin
      led_out_d     = '0;
      fade_active_d = 1'b0;
      for (int i = 0; i < N_LED; i++) begin
         led_out_d[i] = (pwm_cnt_q < duty[i]);
         if (lvl_q[i] != '0) begin
            fade_active_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         presc_q       <= '0;
         pwm_cnt_q     <= '0;
         led_out_q     <= '0;
         fade_active_q <= 1'b0;
         for (int i = 0; i < N_LED; i++) begin
            lvl_q[i] <= '0;
         end
      end else begin
         presc_q       <= presc_d;
         pwm_cnt_q     <= pwm_cnt_d;
         led_out_q     <= led_out_d;
         fade_active_q <= fade_active_d;
         for (int i = 0; i < N_LED; i++) begin
            lvl_q[i] <= lvl_d[i];
         end
      end
   end

   assign bus.led_out     = led_out_q;
   assign bus.fade_active = fade_active_q;

endmodule
